vmul_sched: RTL and testbench

Round-robin scheduler that shares one combinational 8x8 Vedic multiplier (the vedic8bit datapath) among NREQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler registers the granted operands, drives them through the shared multiplier, and returns the 16-bit product tagged with the requester ID on a single response port with backpressure. It sits between the multiplier datapath and the client blocks that need products.

---
 rtl/vmul_sched_if.sv | 25 ++
 rtl/vmul_sched.sv | 184 ++++++++++++++++++
 tb/tb_vmul_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmul_sched_if.sv
// Request/response bundle between the client blocks and the vmul_sched multiplier scheduler.
// master = client side (drives operands, consumes products); slave = scheduler side.
interface vmul_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/vmul_sched.sv
// Round-robin scheduler sharing one combinational 8x8 Vedic multiplier among NREQ requesters.
// Optional macro VMUL_SCHED_PIPE_EN inserts a product register (S1b) between the multiplier and S2.
module vmul_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    vmul_sched_if.slave bus,
    output logic [15:0] done_cnt
);

    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic       c;
        logic [3:0] p;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c    = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c;
        p[3] = (x[1] & y[1]) & c;
        return p;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = vedic4(x[3:0], y[3:0]);
        q1 = vedic4(x[7:4], y[3:0]);
        q2 = vedic4(x[3:0], y[7:4]);
        q3 = vedic4(x[7:4], y[7:4]);
        return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
    endfunction

    logic [7:0]      op_a [NREQ];
    logic [7:0]      op_b [NREQ];
    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            s1_load, s2_load, xfer;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic            v1_q;
    logic [7:0]      a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic [15:0]     mul_p;
    logic            s2_v;
    logic [15:0]     s2_prod;
    logic [IDW-1:0]  s2_id;
    logic            rsp_valid_q;
    logic [15:0]     rsp_prod_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [15:0]     done_cnt_q, done_cnt_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
            assign op_a[gi] = bus.req_a[8*gi +: 8];
            assign op_b[gi] = bus.req_b[8*gi +: 8];
        end
    endgenerate

    // Two-pass priority scan: indices above last_grant first, then wrap from 0 up to last_grant.
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && bus.req_valid[i] && (i > int'(last_grant_q))) begin
                grant_any   = 1'b1;
                grant_oh[i] = 1'b1;
                grant_id    = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && bus.req_valid[i]) begin
                grant_any   = 1'b1;
                grant_oh[i] = 1'b1;
                grant_id    = IDW'(i);
            end
        end
    end

    assign s2_load       = !rsp_valid_q || bus.rsp_ready;
    assign bus.req_ready = (rst_n && s1_load) ? grant_oh : '0;
    assign xfer          = rst_n && s1_load && grant_any;
    assign mul_p         = vedic8(a_q, b_q);

`ifdef VMUL_SCHED_PIPE_EN
    logic           vb_q;
    logic [15:0]    prod_b_q;
    logic [IDW-1:0] id_b_q;
    logic           sb_load;

    assign sb_load = !vb_q || s2_load;
    assign s1_load = !v1_q || sb_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vb_q     <= 1'b0;
            prod_b_q <= '0;
            id_b_q   <= '0;
        end else if (sb_load) begin
            vb_q <= v1_q;
            if (v1_q) begin
                prod_b_q <= mul_p;
                id_b_q   <= id_q;
            end
        end
    end

    assign s2_v    = vb_q;
    assign s2_prod = prod_b_q;
    assign s2_id   = id_b_q;
`else
    assign s1_load = !v1_q || s2_load;
    assign s2_v    = v1_q;
    assign s2_prod = mul_p;
    assign s2_id   = id_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (s1_load) begin
            v1_q <= xfer;
            if (xfer) begin
                a_q  <= op_a[grant_id];
                b_q  <= op_b[grant_id];
                id_q <= grant_id;
            end
        end
    end

    // Products and IDs only move on a valid load, so they stay frozen under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
            rsp_id_q    <= '0;
        end else if (s2_load) begin
            rsp_valid_q <= s2_v;
            if (s2_v) begin
                rsp_prod_q <= s2_prod;
                rsp_id_q   <= s2_id;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        done_cnt_d   = done_cnt_q;
        if (xfer) begin
            last_grant_d = grant_id;
        end
        if (rsp_valid_q && bus.rsp_ready) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            done_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_id    = rsp_id_q;
    assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_vmul_sched.sv
// Self-checking bench for vmul_sched: queue-based reference model plus directed literal checks.
module tb_vmul_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef VMUL_SCHED_PIPE_EN
    localparam int LAT = 3;
    localparam int CAP = 3;
`else
    localparam int LAT = 2;
    localparam int CAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] done_cnt;

    vmul_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    vmul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int prod;
        int rdy;
    } item_t;

    int              checks     = 0;
    int              errors     = 0;
    item_t           q[$];
    int              edge_cnt   = 0;
    int              last_grant = NREQ - 1;
    int              done_m     = 0;
    bit              model_live = 1'b0;
    bit              verbose    = 1'b1;
    logic [NREQ-1:0] xfer_mask  = '0;

    logic [7:0]  lit_a  [NREQ];
    logic [7:0]  lit_b  [NREQ];
    int          lit_id [NREQ];
    logic [15:0] lit_p  [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Round robin: first valid index after lg, wrapping modulo NREQ.
    function automatic int arb(input logic [NREQ-1:0] v, input int lg);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (lg + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Model: in-order queue of at most CAP products; the head becomes visible LAT-1 edges after its transfer.
    always @(negedge clk) begin : compare
        bit              exp_rv;
        int              win;
        logic [NREQ-1:0] exp_ready;
        item_t           it;
        exp_rv = model_live && (q.size() > 0) && (edge_cnt >= q[0].rdy);
        win = -1;
        if (rst_n && ((q.size() < CAP) || bus.rsp_ready)) win = arb(bus.req_valid, last_grant);
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        if (model_live) begin
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
            chk("done_cnt", 32'(done_cnt), 32'(done_m));
            if (exp_rv) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                chk("rsp_prod", 32'(bus.rsp_prod), 32'(q[0].prod));
            end
        end
        xfer_mask = exp_ready;
        if (!rst_n) begin
            q.delete();
            last_grant = NREQ - 1;
            done_m     = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (exp_rv && bus.rsp_ready) begin
                done_m = (done_m + 1) % 65536;
                if (verbose)
                    $display("rsp id=%0d prod=0x%04h done=%0d", q[0].id, q[0].prod[15:0], done_m);
                void'(q.pop_front());
            end
            if (win >= 0) begin
                it.id   = win;
                it.prod = int'(bus.req_a[8*win +: 8]) * int'(bus.req_b[8*win +: 8]);
                it.rdy  = edge_cnt + LAT;
                q.push_back(it);
                last_grant = win;
            end
        end
        edge_cnt++;
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        rst_n = 1'b0;
        bus.req_valid = '0;
        drive_edge();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic run_literal(input logic [NREQ-1:0] v, input int n, input string tag);
        logic [NREQ-1:0] first;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = lit_a[i];
            bus.req_b[8*i +: 8] = lit_b[i];
        end
        bus.req_valid = v;
        first = v & (~v + 1'b1);
        @(negedge clk);
        chk({tag, "_first_ready"}, 32'(bus.req_ready), 32'(first));
        repeat (LAT - 1) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_id"}, 32'(bus.rsp_id), 32'(lit_id[i]));
            chk({tag, "_prod"}, 32'(bus.rsp_prod), 32'(lit_p[i]));
        end
        drive_edge();
        bus.req_valid = '0;
        repeat (2 * LAT + 2) drive_edge();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          cnt;
        int          cyc;
        bit          have;
        logic [15:0] hold_p;
        logic [IDW-1:0] hold_id;

        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with req_ready forced low despite pending requests.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_prod", 32'(bus.rsp_prod), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);

        // Single request 0x0D * 0x0B.
        drive_edge();
        rst_n         = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_a     = 32'h0000_000D;
        bus.req_b     = 32'h0000_000B;
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        drive_edge();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_not_yet", 32'(bus.rsp_valid), 32'd0);
        repeat (LAT - 2) @(negedge clk);
        @(negedge clk);
        chk("single_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_prod", 32'(bus.rsp_prod), 32'h008F);
        chk("single_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        chk("single_done", 32'(done_cnt), 32'd1);

        // All four requesters valid: round-robin order with consecutive products.
        lit_a  = '{8'h11, 8'h22, 8'h33, 8'h44};
        lit_b  = '{8'h02, 8'h02, 8'h02, 8'h02};
        lit_id = '{0, 1, 2, 3};
        lit_p  = '{16'h0022, 16'h0044, 16'h0066, 16'h0088};
        run_literal(4'b1111, 4, "rr");

        // Boundary operands.
        lit_a  = '{8'hFF, 8'h00, 8'h80, 8'h00};
        lit_b  = '{8'hFF, 8'hFF, 8'h02, 8'h00};
        lit_id = '{0, 1, 2, 0};
        lit_p  = '{16'hFE01, 16'h0000, 16'h0100, 16'h0000};
        run_literal(4'b0111, 3, "bound");

        // Backpressure: pipeline fills to CAP, then ready drops and outputs freeze.
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = rand_op();
            bus.req_b[8*i +: 8] = rand_op();
        end
        bus.req_valid = '1;
        cnt  = 0;
        have = 1'b0;
        hold_p  = '0;
        hold_id = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cnt += $countones(bus.req_valid & bus.req_ready);
            if (bus.rsp_valid && !have) begin
                have    = 1'b1;
                hold_p  = bus.rsp_prod;
                hold_id = bus.rsp_id;
            end
        end
        chk("bp_transfers", 32'(cnt), 32'(CAP));
        chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
        chk("bp_has_output", 32'(have), 32'd1);
        chk("bp_prod_stable", 32'(bus.rsp_prod), 32'(hold_p));
        chk("bp_id_stable", 32'(bus.rsp_id), 32'(hold_id));
        drive_edge();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        repeat (CAP + 4) drive_edge();

        // Reset with two products in flight.
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        drive_edge();
        drive_edge();
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_done", 32'(done_cnt), 32'd0);
        chk("midrst_first_grant", 32'(bus.req_ready), 32'h1);
        drive_edge();
        bus.req_valid = '0;
        repeat (2 * LAT + 2) drive_edge();

        // Randomized traffic with random backpressure and occasional request withdrawal.
        for (int c = 0; c < 1500; c++) begin
            drive_edge();
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && !xfer_mask[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i]    = 1'($urandom_range(0, 1));
                    bus.req_a[8*i +: 8] = rand_op();
                    bus.req_b[8*i +: 8] = rand_op();
                end
            end
        end
        drive_edge();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        repeat (CAP + 4) drive_edge();

        // Counter wrap after 65537 accepted responses.
        do_reset();
        verbose       = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        cnt = 0;
        cyc = 0;
        while (cnt < 65537 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid && bus.rsp_ready) cnt++;
        end
        @(negedge clk);
        chk("wrap_count", 32'(cnt), 32'd65537);
        chk("wrap_done_cnt", 32'(done_cnt), 32'h0001);
        drive_edge();
        bus.req_valid = '0;
        repeat (CAP + 4) drive_edge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
